// File: rtl/mult_div_unit_if.sv
// Command/result bundle between the execute stage and the multiply/divide unit.
interface mult_div_unit_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU/DIV/DIVU take one start cycle, 32 iteration cycles and one
// sign-fix cycle; MTHI/MTLO write HI/LO directly from IDLE.
module mult_div_unit (
    input  logic            clk,
    input  logic            rst,
    mult_div_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;

    // Two's-complement absolute value, applied only for signed ops.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

    // Conditional two's-complement negation of a 32-bit value.
    function automatic logic [31:0] cneg32(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

    // Conditional two's-complement negation of a 64-bit value.
    function automatic logic [63:0] cneg64(input logic [63:0] v, input logic neg);
        return neg ? (~v + 64'd1) : v;
    endfunction

    state_e      state_q,    state_d;
    logic [4:0]  cnt_q,      cnt_d;
    logic        is_div_q,   is_div_d;
    logic        neg_res_q,  neg_res_d;   // product / quotient sign
    logic        neg_rem_q,  neg_rem_d;   // remainder follows sign of a
    logic        div_zero_q, div_zero_d;
    logic [31:0] a_raw_q,    a_raw_d;     // original a, for divide-by-zero HI
    logic [31:0] opnd_q,     opnd_d;      // multiplicand or divisor magnitude
    logic [63:0] acc_q,      acc_d;       // product accumulator; [31:0] is quotient shifter for divide
    logic [31:0] rem_q,      rem_d;       // partial remainder
    logic [31:0] hi_q,       hi_d;
    logic [31:0] lo_q,       lo_d;
    logic        busy_q,     busy_d;
    logic        done_q,     done_d;

    logic        arith_start_s;
    logic        signed_op_s;
    logic [32:0] mul_sum_s;
    logic [63:0] mul_next_s;
    logic [32:0] rem_shift_s;
    logic        div_ge_s;
    logic [31:0] div_diff_s;
    logic [63:0] prod_fix_s;
    logic [31:0] quot_fix_s;
    logic [31:0] rem_fix_s;

    assign arith_start_s = bus.start && (bus.op[2] == 1'b0);
    assign signed_op_s   = (bus.op[0] == 1'b0);

    // One shift-add multiply step: conditionally add multiplicand to upper half, shift right.
    assign mul_sum_s  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    assign mul_next_s = {mul_sum_s, acc_q[31:1]};

    // One restoring divide step: bring in next dividend bit, subtract divisor if it fits.
    assign rem_shift_s = {rem_q, acc_q[31]};
    assign div_ge_s    = (rem_shift_s >= {1'b0, opnd_q});
    assign div_diff_s  = rem_shift_s[31:0] - opnd_q;

    // Sign-corrected results presented during FIX.
    assign prod_fix_s = cneg64(acc_q, neg_res_q);
    assign quot_fix_s = cneg32(acc_q[31:0], neg_res_q);
    assign rem_fix_s  = cneg32(rem_q, neg_rem_q);

    // FSM state and iteration counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: IDLE -> RUN on arithmetic start, 32 RUN cycles, then FIX.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (arith_start_s) begin
                    state_d = ST_RUN;
                    cnt_d   = 5'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = ST_FIX;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                cnt_d   = 5'd0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 5'd0;
            end
        endcase
    end

    // Output logic: busy/done and HI/LO write-back, all registered below.
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        hi_d   = hi_q;
        lo_d   = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        3'd0, 3'd1, 3'd2, 3'd3: busy_d = 1'b1;
                        OP_MTHI:                hi_d   = bus.a;
                        OP_MTLO:                lo_d   = bus.a;
                        default:                busy_d = 1'b0;
                    endcase
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_RUN: begin
                busy_d = 1'b1;
            end
            ST_FIX: begin
                done_d = 1'b1;
                if (!is_div_q) begin
                    hi_d = prod_fix_s[63:32];
                    lo_d = prod_fix_s[31:0];
                end else if (div_zero_q) begin
                    // Forced so DIV matches the natural unsigned result.
                    hi_d = a_raw_q;
                    lo_d = 32'hFFFF_FFFF;
                end else begin
                    hi_d = rem_fix_s;
                    lo_d = quot_fix_s;
                end
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // Datapath next values: operand capture on start, one iteration per RUN cycle.
    always_comb begin
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        a_raw_d    = a_raw_q;
        opnd_d     = opnd_q;
        acc_d      = acc_q;
        rem_d      = rem_q;
        case (state_q)
            ST_IDLE: begin
                if (arith_start_s) begin
                    is_div_d   = bus.op[1];
                    neg_res_d  = signed_op_s && (bus.a[31] ^ bus.b[31]);
                    neg_rem_d  = signed_op_s && bus.a[31];
                    div_zero_d = (bus.b == 32'd0);
                    a_raw_d    = bus.a;
                    rem_d      = 32'd0;
                    if (bus.op[1]) begin
                        acc_d  = {32'd0, mag32(bus.a, signed_op_s)};
                        opnd_d = mag32(bus.b, signed_op_s);
                    end else begin
                        acc_d  = {32'd0, mag32(bus.b, signed_op_s)};
                        opnd_d = mag32(bus.a, signed_op_s);
                    end
                end else begin
                    acc_d = acc_q;
                end
            end
            ST_RUN: begin
                if (!is_div_q) begin
                    acc_d = mul_next_s;
                end else if (div_ge_s) begin
                    rem_d = div_diff_s;
                    acc_d = {acc_q[63:32], acc_q[30:0], 1'b1};
                end else begin
                    rem_d = rem_shift_s[31:0];
                    acc_d = {acc_q[63:32], acc_q[30:0], 1'b0};
                end
            end
            default: begin
                acc_d = acc_q;
            end
        endcase
    end

    // Datapath and registered output flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            a_raw_q    <= 32'd0;
            opnd_q     <= 32'd0;
            acc_q      <= 64'd0;
            rem_q      <= 32'd0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            a_raw_q    <= a_raw_d;
            opnd_q     <= opnd_d;
            acc_q      <= acc_d;
            rem_q      <= rem_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed testbench for mult_div_unit: vector table plus busy/reset/MT* sequences.
module tb_mult_div_unit;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mult_div_unit_if bus ();

    mult_div_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue one mul/div op and check latency, held HI/LO, result and single-cycle done.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        logic [31:0] hi0;
        logic [31:0] lo0;
        int          n;
        logic        moved;
        @(negedge clk);
        hi0 = bus.hi;
        lo0 = bus.lo;
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = 32'h5A5A_5A5A;
        bus.b     = 32'hA5A5_A5A5;
        check({name, " busy"}, {31'd0, bus.busy}, 32'd1);
        n     = 0;
        moved = 1'b0;
        while (!bus.done && n < 40) begin
            if (bus.hi !== hi0 || bus.lo !== lo0) moved = 1'b1;
            @(negedge clk);
            n++;
        end
        check({name, " latency"}, n, 32'd33);
        check({name, " hold"}, {31'd0, moved}, 32'd0);
        check({name, " hi"}, bus.hi, exp_hi);
        check({name, " lo"}, bus.lo, exp_lo);
        check({name, " busy_at_done"}, {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        check({name, " done_width"}, {31'd0, bus.done}, 32'd0);
    endtask

    vec_t vecs [11];

    initial begin
        logic [31:0] hi_s;
        logic [31:0] lo_s;
        int          n;
        logic        flag;

        vecs[0]  = '{3'd1, 32'd7,         32'd6,         32'h0000_0000, 32'h0000_002A};
        vecs[1]  = '{3'd0, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[2]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[3]  = '{3'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFA, 32'h0000_0000, 32'h0000_002A};
        vecs[4]  = '{3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[5]  = '{3'd2, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[6]  = '{3'd3, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E};
        vecs[7]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[8]  = '{3'd2, 32'd123,       32'd0,         32'h0000_007B, 32'hFFFF_FFFF};
        vecs[9]  = '{3'd3, 32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0, 32'hFFFF_FFFF};
        vecs[10] = '{3'd2, 32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 32'hFFFF_FFFF};

        // Reset state
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 3'd6;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        #12;
        check("rst hi",   bus.hi, 32'd0);
        check("rst lo",   bus.lo, 32'd0);
        check("rst busy", {31'd0, bus.busy}, 32'd0);
        check("rst done", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Vector table
        for (int i = 0; i < 11; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].exp_hi, vecs[i].exp_lo);
        end

        // MTHI then MTLO on consecutive cycles, then op 6/7 no-ops
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'd4;
        bus.a     = 32'h1234_5678;
        @(negedge clk);
        bus.op    = 3'd5;
        bus.a     = 32'h9ABC_DEF0;
        check("mthi hi",   bus.hi, 32'h1234_5678);
        check("mthi busy", {31'd0, bus.busy}, 32'd0);
        check("mthi done", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        bus.op    = 3'd6;
        bus.a     = 32'h0000_0000;
        check("mtlo lo",   bus.lo, 32'h9ABC_DEF0);
        check("mtlo hi",   bus.hi, 32'h1234_5678);
        check("mtlo busy", {31'd0, bus.busy}, 32'd0);
        check("mtlo done", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        bus.op    = 3'd7;
        bus.a     = 32'h1111_1111;
        check("op6 hi",   bus.hi, 32'h1234_5678);
        check("op6 lo",   bus.lo, 32'h9ABC_DEF0);
        check("op6 busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        bus.start = 1'b0;
        check("op7 hi", bus.hi, 32'h1234_5678);
        check("op7 lo", bus.lo, 32'h9ABC_DEF0);

        // MULTU with an MTHI attempted mid-run
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'd1;
        bus.a     = 32'h0001_2345;
        bus.b     = 32'h0001_0000;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'd4;
        bus.a     = 32'h0000_DEAD;
        @(negedge clk);
        bus.start = 1'b0;
        check("busy mthi ignored", bus.hi, 32'h1234_5678);
        check("busy during run", {31'd0, bus.busy}, 32'd1);
        n = 10;
        while (!bus.done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("busy mul latency", n, 32'd33);
        check("busy mul hi", bus.hi, 32'h0000_0001);
        check("busy mul lo", bus.lo, 32'h2345_0000);
        check("busy on done cycle", {31'd0, bus.busy}, 32'd0);

        // DIVU issued on the done cycle, then reset at cycle 20
        bus.start = 1'b1;
        bus.op    = 3'd3;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b busy", {31'd0, bus.busy}, 32'd1);
        check("b2b done low", {31'd0, bus.done}, 32'd0);
        flag = 1'b0;
        repeat (19) begin
            @(negedge clk);
            if (bus.done) flag = 1'b1;
        end
        check("b2b no early done", {31'd0, flag}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        hi_s = bus.hi;
        lo_s = bus.lo;
        check("abort hi", hi_s, 32'd0);
        check("abort lo", lo_s, 32'd0);
        check("abort busy", {31'd0, bus.busy}, 32'd0);
        check("abort done", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        flag = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done || bus.busy || bus.hi !== 32'd0 || bus.lo !== 32'd0) flag = 1'b1;
        end
        check("abort quiet", {31'd0, flag}, 32'd0);

        // Unit still works after abort
        run_op("post_abort", 3'd1, 32'd7, 32'd6, 32'd0, 32'd42);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
